// File: rtl/branch_cond_unit_pkg.sv
// Shared types and decode helpers for the branch condition unit.
// Holds the condition encoding, the comparator result codes, the FSM
// state type and the function that maps (condition, result code) to taken.
package branch_cond_unit_pkg;

    // Branch condition selector as presented on req_cond (6 and 7 are illegal)
    typedef enum logic [2:0] {
        COND_EQ = 3'd0,
        COND_NE = 3'd1,
        COND_LT = 3'd2,
        COND_GE = 3'd3,
        COND_GT = 3'd4,
        COND_LE = 3'd5
    } cond_e;

    // Comparator result codes; 2'b10 is reserved and reported as an error
    localparam logic [1:0] CMP_EQ  = 2'b00;
    localparam logic [1:0] CMP_GT  = 2'b01;
    localparam logic [1:0] CMP_LT  = 2'b11;
    localparam logic [1:0] CMP_RSV = 2'b10;

    // Request lifecycle: accept, fire the comparator, wait out its latency, respond
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // True when the raw condition value names one of the six real conditions
    function automatic logic cond_legal(input logic [2:0] c);
        return (c <= 3'd5);
    endfunction

    // Condition outcome for a non-reserved result code
    function automatic logic cond_taken(input cond_e c, input logic [1:0] r);
        logic t;
        t = 1'b0;
        case (c)
            COND_EQ: t = (r == CMP_EQ);
            COND_NE: t = (r != CMP_EQ);
            COND_LT: t = (r == CMP_LT);
            COND_GE: t = (r != CMP_LT);
            COND_GT: t = (r == CMP_GT);
            COND_LE: t = (r != CMP_GT);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_cond_unit.sv
// Branch condition unit: accepts one compare request over valid/ready,
// fires a single-cycle execute pulse at the external multi-cycle comparator,
// waits CMP_LAT cycles, decodes the result code and holds the response until
// it is accepted.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds its payload stable until that edge.
// req_ready and rsp_valid are decoded from the state register only.
//
// Optional build macro CMP_STATS_EN adds saturating 16-bit counters of
// handshaken responses (stat_total) and of those that were taken (stat_taken).
module branch_cond_unit
    import branch_cond_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 8,
    parameter int CMP_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_cond,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              cmp_execute,
    output logic [DATA_W-1:0] cmp_a,
    output logic [DATA_W-1:0] cmp_b,
    input  logic [1:0]        cmp_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_taken,
    output logic              rsp_err,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [1:0]        dbg_state
`ifdef CMP_STATS_EN
    ,
    output logic [15:0]       stat_total,
    output logic [15:0]       stat_taken
`endif
);

    localparam int CNT_W = (CMP_LAT < 2) ? 1 : $clog2(CMP_LAT + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          cond_q, cond_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                taken_q, taken_d;
    logic                err_q, err_d;

    logic                legal;
    logic                dec_err;
    logic                dec_taken;

    // Decode the sampled result code; only consumed in the sample cycle
    always_comb begin
        legal     = cond_legal(cond_q);
        dec_err   = !legal || (cmp_result == CMP_RSV);
        dec_taken = !dec_err && cond_taken(cond_e'(legal ? cond_q : 3'd0), cmp_result);
    end

    // Next-state, latency counter and operand/response register updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cond_d  = cond_q;
        a_d     = a_q;
        b_d     = b_q;
        tag_d   = tag_q;
        taken_d = taken_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cond_d  = req_cond;
                    a_d     = req_a;
                    b_d     = req_b;
                    tag_d   = req_tag;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(CMP_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    taken_d = dec_taken;
                    err_d   = dec_err;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any request in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cond_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            taken_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cond_q  <= cond_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            taken_q <= taken_d;
            err_q   <= err_d;
        end
    end

    // Outputs come straight from registered state
    always_comb begin
        req_ready   = (state_q == IDLE);
        cmp_execute = (state_q == ISSUE);
        rsp_valid   = (state_q == RESP);
        cmp_a       = a_q;
        cmp_b       = b_q;
        rsp_taken   = taken_q;
        rsp_err     = err_q;
        rsp_tag     = tag_q;
        dbg_state   = state_q;
    end

`ifdef CMP_STATS_EN
    logic [15:0] total_q, total_d;
    logic [15:0] ntaken_q, ntaken_d;
    logic        rsp_fire;

    // Count completed handshakes, saturating at all-ones
    always_comb begin
        rsp_fire = (state_q == RESP) && rsp_ready;
        total_d  = total_q;
        ntaken_d = ntaken_q;
        if (rsp_fire) begin
            if (total_q != 16'hFFFF) total_d = total_q + 16'd1;
            if (taken_q && (ntaken_q != 16'hFFFF)) ntaken_d = ntaken_q + 16'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_q  <= '0;
            ntaken_q <= '0;
        end else begin
            total_q  <= total_d;
            ntaken_q <= ntaken_d;
        end
    end

    assign stat_total = total_q;
    assign stat_taken = ntaken_q;
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// Bench for branch_cond_unit with a 3-cycle comparator model and a
// reference decision computed from signed operand arithmetic.
module tb_branch_cond_unit;

    localparam int DATA_W  = 32;
    localparam int TAG_W   = 8;
    localparam int CMP_LAT = 3;

    // Clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_cond;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [TAG_W-1:0]  req_tag;
    logic              cmp_execute;
    logic [DATA_W-1:0] cmp_a;
    logic [DATA_W-1:0] cmp_b;
    logic [1:0]        cmp_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_taken;
    logic              rsp_err;
    logic [TAG_W-1:0]  rsp_tag;
    logic [1:0]        dbg_state;
`ifdef CMP_STATS_EN
    logic [15:0]       stat_total;
    logic [15:0]       stat_taken;
`endif

    branch_cond_unit #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CMP_LAT(CMP_LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cond    (req_cond),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_tag     (req_tag),
        .cmp_execute (cmp_execute),
        .cmp_a       (cmp_a),
        .cmp_b       (cmp_b),
        .cmp_result  (cmp_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_taken   (rsp_taken),
        .rsp_err     (rsp_err),
        .rsp_tag     (rsp_tag),
        .dbg_state   (dbg_state)
`ifdef CMP_STATS_EN
        ,
        .stat_total  (stat_total),
        .stat_taken  (stat_taken)
`endif
    );

    // Scoreboard: {err, taken, tag}
    logic [TAG_W+1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int hs_total = 0;
    int hs_taken = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Comparator model: code from the sign of A-B, valid CMP_LAT cycles after execute
    bit         force_bad = 1'b0;
    int         m_cd = 0;
    logic [1:0] m_code;

    function automatic logic [1:0] model_code(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        d = a - b;
        if (d == 32'd0) return 2'b00;
        else if (d[31]) return 2'b11;
        else return 2'b01;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cd = 0;
            cmp_result <= 2'(($urandom_range(0, 3)));
        end else if (cmp_execute) begin
            m_code = model_code(cmp_a, cmp_b);
            m_cd = CMP_LAT - 1;
            cmp_result <= 2'($urandom_range(0, 3));
        end else if (m_cd > 0) begin
            m_cd = m_cd - 1;
            if (m_cd == 0) cmp_result <= force_bad ? 2'b10 : m_code;
            else cmp_result <= 2'($urandom_range(0, 3));
        end else begin
            cmp_result <= 2'($urandom_range(0, 3));
        end
    end

    // Reference decision: {err, taken} from the condition rules on signed A-B
    function automatic logic [1:0] ref_rsp(input int cond, input logic [31:0] a,
                                           input logic [31:0] b, input bit bad);
        logic eq, lt, gt, t;
        if (cond > 5 || bad) return 2'b10;
        eq = (a == b);
        lt = ($signed(a - b) < 0);
        gt = !eq && !lt;
        case (cond)
            0: t = eq;
            1: t = !eq;
            2: t = lt;
            3: t = !lt;
            4: t = gt;
            default: t = !gt;
        endcase
        return {1'b0, t};
    endfunction

    // Driver: one full request/response transaction
    task automatic run_req(input logic [2:0] cond, input logic [31:0] a, input logic [31:0] b,
                           input logic [7:0] tag, input int hold, input bit bad);
        int n;
        int n_exec;
        logic [1:0] er;
        logic [TAG_W+1:0] exp;
        logic [TAG_W+1:0] snap;
        force_bad = bad;
        @(negedge clk);
        check("req_ready_idle", req_ready, 1'b1);
        er = ref_rsp(int'(cond), a, b, bad);
        exp_q.push_back({er, tag});
        req_valid = 1'b1;
        req_cond  = cond;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_cond  = 3'($urandom_range(0, 7));
        req_a     = $urandom;
        req_b     = $urandom;
        req_tag   = 8'($urandom);
        n = 1;
        n_exec = 0;
        while (!rsp_valid && n < 20) begin
            if (cmp_execute) begin
                n_exec++;
                check("exec_cycle", n, 1);
            end
            check("busy_not_ready", req_ready, 1'b0);
            check("cmp_a_stable", cmp_a, a);
            check("cmp_b_stable", cmp_b, b);
            @(negedge clk);
            n++;
        end
        check("rsp_latency", n, CMP_LAT + 2);
        check("exec_count", n_exec, 1);
        exp = exp_q.pop_front();
        check("rsp_fields", {rsp_err, rsp_taken, rsp_tag}, exp);
        snap = {rsp_err, rsp_taken, rsp_tag};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_fields", {rsp_err, rsp_taken, rsp_tag}, snap);
            check("hold_not_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        if (rsp_valid) begin
            hs_total++;
            if (exp[TAG_W]) hs_taken++;
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", rsp_valid, 1'b0);
        check("back_idle", req_ready, 1'b1);
        force_bad = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, req_ready, 1'b1);
        check({tag, "_exec"}, cmp_execute, 1'b0);
        check({tag, "_cmp_ab"}, {cmp_a, cmp_b}, 64'd0);
        check({tag, "_rsp"}, {rsp_valid, rsp_taken, rsp_err, rsp_tag}, 64'd0);
        check({tag, "_state"}, dbg_state, 2'd0);
`ifdef CMP_STATS_EN
        check({tag, "_stats"}, {stat_total, stat_taken}, 64'd0);
`endif
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_cond  = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("post_reset");

        // Directed cases
        run_req(3'd0, 32'd5, 32'd5, 8'hA5, 0, 1'b0);          // EQ taken
        run_req(3'd2, 32'hFFFF_FFFF, 32'd1, 8'h11, 0, 1'b0);  // LT taken
        run_req(3'd3, 32'hFFFF_FFFF, 32'd1, 8'h12, 1, 1'b0);  // GE not taken
        run_req(3'd4, 32'd7, 32'd3, 8'h13, 0, 1'b0);          // GT taken
        run_req(3'd5, 32'd7, 32'd3, 8'h14, 2, 1'b0);          // LE not taken
        run_req(3'd6, 32'd1, 32'd1, 8'h15, 0, 1'b0);          // illegal cond
        run_req(3'd0, 32'd9, 32'd9, 8'h16, 0, 1'b1);          // reserved code
        run_req(3'd1, 32'd4, 32'd8, 8'h17, 10, 1'b0);         // long backpressure

        // Asynchronous reset while waiting on the comparator
        @(negedge clk);
        req_valid = 1'b1;
        req_cond  = 3'd0;
        req_a     = 32'd3;
        req_b     = 32'd3;
        req_tag   = 8'h77;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("in_wait", dbg_state, 2'd2);
        #2 reset = 1'b0;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        reset = 1'b1;
        run_req(3'd2, 32'd2, 32'd9, 8'h78, 0, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            logic [31:0] b;
            int sel;
            sel = $urandom_range(0, 3);
            a = $urandom;
            b = $urandom;
            if (sel == 0) b = a;
            else if (sel == 1) begin
                a = 32'($urandom_range(0, 6)) - 32'd3;
                b = 32'($urandom_range(0, 6)) - 32'd3;
            end else if (sel == 2) begin
                a = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                b = 32'($urandom_range(0, 2)) - 32'd1;
            end
            run_req(3'($urandom_range(0, 7)), a, b, 8'($urandom),
                    $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
        end

`ifdef CMP_STATS_EN
        check("stat_total", stat_total, 16'(hs_total));
        check("stat_taken", stat_taken, 16'(hs_taken));
`endif
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
